mem_rr_sched: RTL
=================

# mem_rr_sched

Round-robin transaction scheduler that shares the single `mem_ctrl` port among four requesters: CPU fetch, CPU data, FPU MMIO, and FPU DMA. It grants one whole transaction at a time and holds the grant until `mem_ctrl` reports completion. It routes completion and read data back to the granted requester only, and aborts hung transactions with a watchdog. It sits between the requester controllers and `mem_ctrl` inside `afu`.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesters. Fixed at 4 in this revision.
- `ADDR_W`, default 32: requester address width.
- `DATA_W`, default 512: cache-line data width.
- `TIMEOUT_CYCLES`, default 1024: maximum BUSY cycles before abort. Must be ≥2.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `op_src` in [NUM_SRC][2]: per-requester op. 00 = none, 01 = read, 10 = write, 11 = reserved (treated as none).
- `raw_address_src` in [NUM_SRC][ADDR_W]: per-requester address.
- `common_data_bus_read_in_src` in [NUM_SRC][DATA_W]: per-requester write data.
- `common_data_bus_write_out_src` out [NUM_SRC][DATA_W]: read data to each requester.
- `tx_done_src` out [NUM_SRC]: completion pulse to each requester.
- `rd_valid_src` out [NUM_SRC]: read-data-valid to each requester.
- `op` out 2: op to `mem_ctrl`.
- `raw_address` out ADDR_W: address to `mem_ctrl`.
- `common_data_bus_read_in` out DATA_W: write data to `mem_ctrl`.
- `common_data_bus_write_out` in DATA_W: read data from `mem_ctrl`.
- `tx_done` in 1: completion from `mem_ctrl`.
- `rd_valid` in 1: read valid from `mem_ctrl`.
- `grant_id` out 2: current or last granted requester.
- `busy` out 1: high in BUSY.
- `timeout_err` out 1: sticky; set on any watchdog abort.

## Operation
- **States:** IDLE, BUSY, RELEASE.
- **IDLE:**
  - Requester i is eligible when `op_src[i]` is 01 or 10.
  - The winner is the first eligible index searched from `ptr`, `ptr+1`, … mod 4.
  - On a winner: register `grant_id`, `op`, `raw_address` and write data from the winner, clear the watchdog, and go to BUSY.
- **BUSY:**
  - `op`, `raw_address` and `common_data_bus_read_in` are held from the registers, not live inputs.
  - `tx_done_src[grant_id] = tx_done`.
  - `rd_valid_src[grant_id] = rd_valid`.
  - `common_data_bus_write_out_src[grant_id] = common_data_bus_write_out`.
  - For every other requester, tx_done and rd_valid are 0 and the data outputs are 0.
  - On `tx_done`: go to RELEASE, register `op` to 00, and set `ptr = grant_id+1` mod 4.
- **Watchdog:**
  - The counter increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES-1` without `tx_done`, the block forces `tx_done_src[grant_id]=1` for that cycle, sets `timeout_err`, and takes the same transition as a normal `tx_done`.
  - `rd_valid_src` stays 0 on an abort.
- **RELEASE:** one cycle with requester ops ignored, so a stale op cannot be re-granted; then go to IDLE.
- **Requester contract:**
  - Hold op, address and data stable from assertion until `tx_done_src`.
  - Drop op no later than the cycle after `tx_done_src`.
- **`mem_ctrl` behaviour:**
  - `tx_done` or `rd_valid` arriving in IDLE or RELEASE is ignored and not routed.
  - A simultaneous `tx_done` and watchdog expiry counts as normal completion; `timeout_err` is not set.

## Timing
- **Reset values:**
  - `op`=00, `raw_address`=0, `common_data_bus_read_in`=0.
  - `grant_id`=0, `ptr`=0, `busy`=0, `timeout_err`=0, state=IDLE.
  - All `*_src` outputs are 0.
- **Mid-operation reset:** an asserted `rst` returns everything to the reset values immediately (asynchronously). No completion pulse is emitted.
- **Grant latency:** a request sampled in IDLE at cycle N drives `op` at N+1.
- **Completion path:**
  - `tx_done` at cycle M reaches the requester combinationally in cycle M.
  - `op`=00 from M+1; RELEASE at M+1; IDLE at M+2.
  - The earliest next downstream `op` is at M+3.
- **Read data:** `rd_valid` and its data pass through with zero latency while BUSY.
- **`busy`:** registered; high exactly for the BUSY cycles.

## Structure
- Package `mem_arb_pkg`:
  - `op_t` enum: OP_NONE=2'b00, OP_READ=2'b01, OP_WRITE=2'b10.
  - `src_id_t` (2 bits), `NUM_SRC`=4.
  - `state_t` (IDLE/BUSY/RELEASE).
- Sub-module `mem_rr_pick`: combinational rotate-priority picker.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `valid`, `winner[1:0]`.
- The FSM, capture registers, watchdog and output routing live in `mem_rr_sched`.

## Test plan
1. **Single read:** src2 read at address 0x100; `mem_ctrl` returns `tx_done`+`rd_valid` with data 0xA5… after 5 cycles.
   - Expect `op`=01 one cycle after the request and `raw_address`=0x100.
   - Only src2 sees `rd_valid`, data and `tx_done`; `ptr`=3.
2. **All-four contention:** all four requesters assert writes at reset.
   - Expect grants in order 0,1,2,3.
   - Re-asserting src0 immediately after completion is granted only after 1, 2 and 3.
3. **Stability:** src1 changes its address input while BUSY.
   - Expect downstream `raw_address` unchanged until `tx_done`.
4. **Stale op:** src0 holds op one cycle past `tx_done`, with src3 requesting.
   - Expect the RELEASE cycle to ignore src0 and src3 to be granted next.
5. **Timeout:** with `TIMEOUT_CYCLES`=8, `mem_ctrl` never completes.
   - Expect `tx_done_src[grant_id]` pulsed on the 8th BUSY cycle, `timeout_err`=1 sticky, and `op`=00 the next cycle.
6. **Reset mid-BUSY:** assert `rst` during a src3 write.
   - Expect `op`=00, `busy`=0 and `grant_id`=0 without waiting for a clock edge.
   - After release, a src1 request is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_ctrl port scheduler: op encoding, requester id, FSM states.
package mem_arb_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 2;

  typedef logic [SRC_W-1:0] src_id_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  // Reserved encoding 2'b11 counts as no request.
  function automatic logic op_is_req(input logic [1:0] op);
    return (op == 2'(OP_READ)) || (op == 2'(OP_WRITE));
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Rotate-priority picker: first asserted request searched from ptr upward, modulo 4.
module mem_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mem_rr_sched.sv
// Round-robin whole-transaction scheduler sharing the mem_ctrl port among four requesters,
// with per-requester completion/read-data routing and a watchdog abort.
module mem_rr_sched
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0][1:0]        op_src,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0] raw_address_src,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] common_data_bus_read_in_src,
  output logic [NUM_SRC-1:0][DATA_W-1:0] common_data_bus_write_out_src,
  output logic [NUM_SRC-1:0]             tx_done_src,
  output logic [NUM_SRC-1:0]             rd_valid_src,
  output logic [1:0]                     op,
  output logic [ADDR_W-1:0]              raw_address,
  output logic [DATA_W-1:0]              common_data_bus_read_in,
  input  logic [DATA_W-1:0]              common_data_bus_write_out,
  input  logic                           tx_done,
  input  logic                           rd_valid,
  output logic [1:0]                     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q;
  src_id_t             ptr_q;
  src_id_t             grant_q;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    wd_q;
  logic                busy_q;
  logic                terr_q;

  logic [3:0]          req_c;
  logic                pick_valid_c;
  logic [1:0]          pick_winner_c;
  logic                in_busy_c;
  logic                expire_c;
  logic                abort_c;
  logic                done_c;

  always_comb begin
    req_c = '0;
    for (int i = 0; i < 4; i++) req_c[i] = op_is_req(op_src[i]);
  end

  mem_rr_pick u_pick (
    .req    (req_c),
    .ptr    (ptr_q),
    .valid  (pick_valid_c),
    .winner (pick_winner_c)
  );

  // A real tx_done on the expiry cycle wins over the watchdog.
  assign in_busy_c = (state_q == ST_BUSY);
  assign expire_c  = in_busy_c && (wd_q == WD_LAST);
  assign abort_c   = expire_c && !tx_done;
  assign done_c    = in_busy_c && (tx_done || expire_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      op_q    <= 2'(OP_NONE);
      addr_q  <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_c) begin
            state_q <= ST_BUSY;
            grant_q <= pick_winner_c;
            op_q    <= op_src[pick_winner_c];
            addr_q  <= raw_address_src[pick_winner_c];
            wdata_q <= common_data_bus_read_in_src[pick_winner_c];
            wd_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (done_c) begin
            state_q <= ST_RELEASE;
            op_q    <= 2'(OP_NONE);
            ptr_q   <= grant_q + 2'd1;
            busy_q  <= 1'b0;
            if (abort_c) terr_q <= 1'b1;
          end else begin
            wd_q <= wd_q + CNT_W'(1);
          end
        end
        // Single dead cycle so a requester still holding a finished op is not re-granted.
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_done_src                   = '0;
    rd_valid_src                  = '0;
    common_data_bus_write_out_src = '0;
    if (in_busy_c) begin
      tx_done_src[grant_q]                   = done_c;
      rd_valid_src[grant_q]                  = rd_valid && !abort_c;
      common_data_bus_write_out_src[grant_q] = common_data_bus_write_out;
    end
  end

  assign op                      = op_q;
  assign raw_address             = addr_q;
  assign common_data_bus_read_in = wdata_q;
  assign grant_id                = grant_q;
  assign busy                    = busy_q;
  assign timeout_err             = terr_q;

endmodule
